// File: rtl/mips_mem_responder_pkg.sv
// Shared MIPS types and memory-responder constants (MMIO map, loader FSM states).
// The optional cycle timer is controlled by the macro MIPS_MEM_TIMER_EN in the top.
package MIPS_pkg;

    localparam int MIPS_PC_WIDTH   = 32;
    localparam int MIPS_DATA_WIDTH = 32;

    typedef logic [MIPS_PC_WIDTH-1:0]   mips_pc_t;
    typedef logic [MIPS_DATA_WIDTH-1:0] mips_data_t;

    typedef enum logic {
        MEM_LOAD = 1'b0,
        MEM_RUN  = 1'b1
    } mips_mem_state_e;

    localparam mips_pc_t   MIPS_MMIO_BASE       = 32'hFFFF_0000;
    localparam logic [3:0] MIPS_MMIO_GPIO_OFS   = 4'h0;
    localparam logic [3:0] MIPS_MMIO_TIMER_OFS  = 4'h4;
    localparam logic [3:0] MIPS_MMIO_STATUS_OFS = 4'h8;

endpackage

// File: rtl/mips_mem_responder_loader.sv
// Program-loader FSM: streams words into RAM while holding the core in reset,
// then releases the core and hands the RAM write port over to it.
module mips_mem_loader
    import MIPS_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    input  logic          load_last,
    output logic          load_ready,
    output logic          cpu_rst_n,
    output logic          o_load_we,
    output logic [AW-1:0] o_load_ptr,
    output logic          o_sel_loader,
    output logic          o_run
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    mips_mem_state_e r_state;
    mips_mem_state_e w_state_next;
    logic [AW-1:0]   r_ptr;
    logic            r_cpu_rst_n;
    logic            w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MEM_LOAD;
            r_ptr       <= '0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_rst_n <= (w_state_next == MEM_RUN);
            // The pointer saturates on the last word instead of wrapping.
            if (w_accept && (r_ptr != LAST_PTR)) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        load_ready   = 1'b0;
        case (r_state)
            MEM_LOAD: begin
                load_ready = 1'b1;
                w_accept   = load_valid;
                if (w_accept && (load_last || (r_ptr == LAST_PTR))) begin
                    w_state_next = MEM_RUN;
                end
            end
            MEM_RUN: begin
                w_state_next = MEM_RUN;
            end
            default: begin
                w_state_next = MEM_LOAD;
            end
        endcase
    end

    assign cpu_rst_n    = r_cpu_rst_n;
    assign o_load_we    = w_accept;
    assign o_load_ptr   = r_ptr;
    assign o_sel_loader = (r_state == MEM_LOAD);
    assign o_run        = (r_state == MEM_RUN);

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multi-cycle MIPS core: word RAM, 16-byte MMIO window and loader.
// Define MIPS_MEM_TIMER_EN to build the free-running cycle counter at MMIO offset 0x4.
module mips_mem_responder
    import MIPS_pkg::*;
#(
    parameter int       DEPTH     = 1024,
    parameter mips_pc_t MMIO_BASE = MIPS_MMIO_BASE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mips_pc_t   addr_mem,
    input  mips_data_t wr_data_mem,
    input  logic       wr_en_mem,
    output mips_data_t rd_data_mem,
    input  logic       load_valid,
    input  mips_data_t load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_rst_n,
    output mips_data_t gpio_out
);

    localparam int AW = $clog2(DEPTH);

    mips_data_t    r_ram [DEPTH];
    mips_data_t    r_gpio;
    logic          w_load_we;
    logic [AW-1:0] w_load_ptr;
    logic          w_sel_loader;
    logic          w_run;
    logic [AW-1:0] w_word;
    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic [3:0]    w_ofs;
    logic          w_core_we;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    mips_data_t    w_ram_wdata;
    mips_data_t    w_timer;
    logic          w_unused_addr;

    mips_mem_loader #(.DEPTH(DEPTH)) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .cpu_rst_n    (cpu_rst_n),
        .o_load_we    (w_load_we),
        .o_load_ptr   (w_load_ptr),
        .o_sel_loader (w_sel_loader),
        .o_run        (w_run)
    );

    assign w_word        = addr_mem[AW+1:2];
    assign w_ram_hit     = (addr_mem[MIPS_PC_WIDTH-1:AW+2] == '0);
    assign w_mmio_hit    = (addr_mem[MIPS_PC_WIDTH-1:4] == MMIO_BASE[MIPS_PC_WIDTH-1:4]);
    assign w_ofs         = {addr_mem[3:2], 2'b00};
    assign w_core_we     = w_run && wr_en_mem;
    assign w_unused_addr = ^addr_mem[1:0];

    // The loader owns the RAM write port in LOAD; the core owns it in RUN.
    assign w_ram_we    = w_sel_loader ? w_load_we  : (w_core_we && w_ram_hit);
    assign w_ram_addr  = w_sel_loader ? w_load_ptr : w_word;
    assign w_ram_wdata = w_sel_loader ? load_data  : wr_data_mem;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio <= '0;
        end else if (w_core_we && w_mmio_hit && (w_ofs == MIPS_MMIO_GPIO_OFS)) begin
            r_gpio <= wr_data_mem;
        end
    end

`ifdef MIPS_MEM_TIMER_EN
    mips_data_t r_timer;

    // A core write restarts the count; the written data itself is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (!w_run) begin
            r_timer <= '0;
        end else if (wr_en_mem && w_mmio_hit && (w_ofs == MIPS_MMIO_TIMER_OFS)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    always_comb begin
        rd_data_mem = '0;
        if (w_run) begin
            if (w_ram_hit) begin
                rd_data_mem = r_ram[w_word];
            end else if (w_mmio_hit) begin
                case (w_ofs)
                    MIPS_MMIO_GPIO_OFS:   rd_data_mem = r_gpio;
                    MIPS_MMIO_TIMER_OFS:  rd_data_mem = w_timer;
                    MIPS_MMIO_STATUS_OFS: rd_data_mem = 32'h0000_0001;
                    default:              rd_data_mem = '0;
                endcase
            end
        end
    end

    assign gpio_out = r_gpio;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed loader/MMIO steps plus
// randomized RAM traffic checked against a simple array model of the memory map.
module tb_mips_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_mem;
    logic [31:0] wr_data_mem;
    logic        wr_en_mem;
    logic [31:0] rd_data_mem;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_rst_n;
    logic [31:0] gpio_out;

    int          errors = 0;
    int          checks = 0;

    // Reference model: memory words with a written flag, GPIO, timer, run flag.
    logic [31:0] memM [DEPTH];
    bit          vldM [DEPTH];
    logic [31:0] gpioM;
    logic [31:0] timerM;
    bit          runM;

    mips_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_mem    (addr_mem),
        .wr_data_mem (wr_data_mem),
        .wr_en_mem   (wr_en_mem),
        .rd_data_mem (rd_data_mem),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_rst_n   (cpu_rst_n),
        .gpio_out    (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the timer model counts every RUN cycle unless cleared by a write.
    task automatic tick(input bit timerClear);
        @(posedge clk);
        #1;
        if (runM) begin
`ifdef MIPS_MEM_TIMER_EN
            timerM = timerClear ? 32'h0 : timerM + 1;
`else
            timerM = 32'h0;
`endif
        end
    endtask

    function automatic bit expRead(input logic [31:0] a, output logic [31:0] v);
        v = 32'h0;
        if (!runM) return 1'b1;
        if (a < DEPTH * 4) begin
            v = memM[a[31:2]];
            return vldM[a[31:2]];
        end
        if (a[31:4] == MMIO[31:4]) begin
            case (a[3:2])
                2'd0: v = gpioM;
                2'd1: v = timerM;
                2'd2: v = 32'h1;
                default: v = 32'h0;
            endcase
        end
        return 1'b1;
    endfunction

    // One core bus cycle: check the combinational read, then commit on the edge.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] d, input bit we);
        logic [31:0] exp;
        bit          known;
        bit          tclr;
        addr_mem    = a;
        wr_data_mem = d;
        wr_en_mem   = we;
        #1;
        known = expRead(a, exp);
        if (known) checkOutput(tag, rd_data_mem, exp);
        tclr = we && runM && (a[31:4] == MMIO[31:4]) && (a[3:2] == 2'd1);
        tick(tclr);
        if (we && runM) begin
            if (a < DEPTH * 4) begin
                memM[a[31:2]] = d;
                vldM[a[31:2]] = 1'b1;
            end else if ((a[31:4] == MMIO[31:4]) && (a[3:2] == 2'd0)) begin
                gpioM = d;
            end
        end
        wr_en_mem = 1'b0;
    endtask

    task automatic loadWord(input int idx, input logic [31:0] d, input bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick(1'b0);
        memM[idx]  = d;
        vldM[idx]  = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [31:0] a;
        logic [31:0] d;
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020;
        prog[3] = 32'hAC0A_0040;
        rst_n = 1'b0; addr_mem = '0; wr_data_mem = '0; wr_en_mem = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        gpioM = '0; timerM = '0; runM = 1'b0;
        for (int i = 0; i < DEPTH; i++) vldM[i] = 1'b0;

        #12;
        checkOutput("reset_load_ready", {31'b0, load_ready}, 32'h1);
        checkOutput("reset_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
        checkOutput("reset_gpio", gpio_out, 32'h0);
        checkOutput("reset_rd_data", rd_data_mem, 32'h0);
        rst_n = 1'b1;
        tick(1'b0);

        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checkOutput("last_hs_load_ready", {31'b0, load_ready}, 32'h1);
                checkOutput("last_hs_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
            end
            loadWord(i, prog[i], i == 3);
        end
        runM = 1'b1; timerM = '0;
        checkOutput("run_load_ready", {31'b0, load_ready}, 32'h0);
        checkOutput("run_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h1);
        applyStimulus("read_0x8", 32'h8, 32'h0, 1'b0);

        applyStimulus("pre_write_0x40", 32'h40, 32'h0000_0011, 1'b1);
        applyStimulus("rdw_old_0x40", 32'h40, 32'h0000_002A, 1'b1);
        applyStimulus("read_0x40", 32'h40, 32'h0, 1'b0);

        applyStimulus("gpio_write", MMIO, 32'hDEAD_BEEF, 1'b1);
        checkOutput("gpio_out", gpio_out, 32'hDEAD_BEEF);
        applyStimulus("status_write", MMIO + 8, 32'h1234_5678, 1'b1);
        applyStimulus("status_read", MMIO + 8, 32'h0, 1'b0);
        applyStimulus("ofs_c_write", MMIO + 12, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("ofs_c_read", MMIO + 12, 32'h0, 1'b0);
        applyStimulus("gpio_read", MMIO, 32'h0, 1'b0);

        applyStimulus("oob_write", DEPTH * 4, 32'h55, 1'b1);
        applyStimulus("oob_read", DEPTH * 4, 32'h0, 1'b0);
        applyStimulus("word0_intact", 32'h0, 32'h0, 1'b0);

        // Timer: written at cycle t, sampled at t+1 and again five cycles later.
        applyStimulus("timer_write", MMIO + 4, 32'hABCD_0000, 1'b1);
        applyStimulus("timer_t1", MMIO + 4, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0);
        applyStimulus("timer_t6", MMIO + 4, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = MMIO + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            else a = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            d = $urandom;
            applyStimulus("rand_access", a, d, 1'($urandom_range(0, 1)));
        end

        applyStimulus("gpio_one", MMIO, 32'h1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
        checkOutput("midrun_gpio", gpio_out, 32'h0);
        checkOutput("midrun_load_ready", {31'b0, load_ready}, 32'h1);
        runM = 1'b0; gpioM = '0; timerM = '0;
        #4;
        rst_n = 1'b1;
        tick(1'b0);

        loadWord(0, $urandom, 1'b0);
        applyStimulus("load_core_write", 32'h0, 32'hBAD0_BAD0, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checkOutput("auto_pre_ready", {31'b0, load_ready}, 32'h1);
                checkOutput("auto_pre_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h0);
            end
            loadWord(i, $urandom, 1'b0);
        end
        runM = 1'b1; timerM = '0;
        checkOutput("auto_load_ready", {31'b0, load_ready}, 32'h0);
        checkOutput("auto_cpu_rst_n", {31'b0, cpu_rst_n}, 32'h1);
        applyStimulus("auto_word0", 32'h0, 32'h0, 1'b0);
        applyStimulus("auto_word_last", (DEPTH - 1) * 4, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("auto_rand_read", {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00}, 32'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
